// File: rtl/uart_tx16_if.sv
// uart_tx16_if: byte-queue side of the 16x-clocked UART transmitter.
//   din      byte to queue
//   wr_en    write strobe, one byte per clock while high
//   full     queue holds 2**FIFO_AW bytes
//   count    current queue occupancy (0..2**FIFO_AW)
//   overflow sticky flag, a write was attempted while full
// master: producer side (drives din/wr_en); slave: the transmitter.
interface uart_tx16_if #(
    parameter int FIFO_AW = 2
);
    logic [7:0]       din;
    logic             wr_en;
    logic             full;
    logic [FIFO_AW:0] count;
    logic             overflow;

    modport master (output din, wr_en, input full, count, overflow);
    modport slave  (input din, wr_en, output full, count, overflow);
endinterface

// File: rtl/uart_tx16.sv
// uart_tx16: buffered RS-232 transmitter running directly on the 16x baud
// clock. Bytes are queued in a 2**FIFO_AW entry FIFO and sent as 8N1 frames
// (8E1 when UART_TX16_PARITY_EN is defined), 16 clocks per bit, back to back
// with no idle gap while the queue is non-empty.
// Ports:
//   clk_9600_16  16x baud clock, all state on the rising edge
//   rst          asynchronous active-high reset
//   bus          uart_tx16_if.slave: din, wr_en, full, count, overflow
//   tx           registered serial line, idle high
//   tx_busy      queue non-empty or a frame in progress
// Parameters: FIFO_AW (queue address width), STOP_BITS (1 or 2).
// Optional build macro: UART_TX16_PARITY_EN adds an even-parity bit.
//
// state  | meaning
// IDLE   | line high, waiting for a queued byte
// START  | start bit (low) for 16 clocks
// DATA   | data bits LSB first, 16 clocks each
// PARITY | even parity of the data byte (parity builds only)
// STOP   | line high for 16*STOP_BITS clocks
module uart_tx16 #(
    parameter int FIFO_AW   = 2,
    parameter int STOP_BITS = 1
) (
    input  logic        clk_9600_16,
    input  logic        rst,
    uart_tx16_if.slave  bus,
    output logic        tx,
    output logic        tx_busy
);
    localparam int CW    = FIFO_AW + 1;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX16_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    // ---------------- FIFO ----------------
    logic [7:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   cnt;
    logic               full, empty, push, pop, ovf;

    assign full  = (cnt == DEPTH_C);
    assign empty = (cnt == '0);
    // full is the pre-edge value, so a pop in the same cycle cannot rescue a write
    assign push  = bus.wr_en && !full;

    assign bus.full     = full;
    assign bus.count    = cnt;
    assign bus.overflow = ovf;

    always_ff @(posedge clk_9600_16) begin
        if (push) begin
            mem[wr_ptr] <= bus.din;
        end
    end

    always_ff @(posedge clk_9600_16 or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + FIFO_AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + FIFO_AW'(1);
            end
            cnt <= cnt + CW'(push) - CW'(pop);
            if (bus.wr_en && full) begin
                ovf <= 1'b1;
            end
        end
    end

    // ---------------- serializer ----------------
    state_t      state, state_n;
    logic [3:0]  sample, sample_n;
    logic [2:0]  bitpos, bitpos_n;
    logic [7:0]  shreg, shreg_n;
    logic        stop_hi, stop_hi_n;
    logic        tx_n;
    logic        bit_end, stop_last;

    assign bit_end = (sample == 4'hf);
    // stop counter is {stop_hi, sample}; with one stop bit the low half suffices
    assign stop_last = (STOP_BITS == 1) || stop_hi;

    always_comb begin
        state_n   = state;
        tx_n      = tx;
        sample_n  = sample + 4'd1;
        bitpos_n  = bitpos;
        shreg_n   = shreg;
        stop_hi_n = stop_hi;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                sample_n  = '0;
                stop_hi_n = 1'b0;
                if (!empty) begin
                    pop     = 1'b1;
                    shreg_n = mem[rd_ptr];
                    tx_n    = 1'b0;
                    state_n = START;
                end else begin
                    tx_n = 1'b1;
                end
            end
            START: begin
                if (bit_end) begin
                    tx_n     = shreg[0];
                    bitpos_n = '0;
                    state_n  = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    if (bitpos == 3'd7) begin
`ifdef UART_TX16_PARITY_EN
                        tx_n    = ^shreg;
                        state_n = PARITY;
`else
                        tx_n      = 1'b1;
                        stop_hi_n = 1'b0;
                        state_n   = STOP;
`endif
                    end else begin
                        bitpos_n = bitpos + 3'd1;
                        tx_n     = shreg[bitpos + 3'd1];
                    end
                end
            end
`ifdef UART_TX16_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    tx_n      = 1'b1;
                    stop_hi_n = 1'b0;
                    state_n   = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    if (stop_last) begin
                        stop_hi_n = 1'b0;
                        // next byte starts on the very next clock: no idle gap
                        if (!empty) begin
                            pop     = 1'b1;
                            shreg_n = mem[rd_ptr];
                            tx_n    = 1'b0;
                            state_n = START;
                        end else begin
                            tx_n    = 1'b1;
                            state_n = IDLE;
                        end
                    end else begin
                        stop_hi_n = 1'b1;
                    end
                end
            end
            default: begin
                tx_n    = 1'b1;
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_9600_16 or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tx      <= 1'b1;
            sample  <= '0;
            bitpos  <= '0;
            shreg   <= '0;
            stop_hi <= 1'b0;
        end else begin
            state   <= state_n;
            tx      <= tx_n;
            sample  <= sample_n;
            bitpos  <= bitpos_n;
            shreg   <= shreg_n;
            stop_hi <= stop_hi_n;
        end
    end

    assign tx_busy = !empty || (state != IDLE);
endmodule

// File: tb/tb_uart_tx16.sv
// Testbench for uart_tx16: two instances (one and two stop bits) share clock,
// reset and stimulus. A frame-level model predicts tx, tx_busy, count, full
// and overflow every clock; a few literal expectations pin the model.
module tb_uart_tx16;
`ifdef UART_TX16_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_s  = 1'b0;
    logic [7:0] din_s = 8'h00;
    logic       tx0, tx1, busy0, busy1;
    bit         chk_en = 1'b0;
    int         n_tests = 0;
    int         n_fail  = 0;

    always #5 clk = ~clk;

    uart_tx16_if #(.FIFO_AW(2)) bus0 ();
    uart_tx16_if #(.FIFO_AW(2)) bus1 ();

    assign bus0.din   = din_s;
    assign bus0.wr_en = wr_s;
    assign bus1.din   = din_s;
    assign bus1.wr_en = wr_s;

    uart_tx16 #(.FIFO_AW(2), .STOP_BITS(1)) dut0 (
        .clk_9600_16(clk), .rst(rst), .bus(bus0), .tx(tx0), .tx_busy(busy0));
    uart_tx16 #(.FIFO_AW(2), .STOP_BITS(2)) dut1 (
        .clk_9600_16(clk), .rst(rst), .bus(bus1), .tx(tx1), .tx_busy(busy1));

    task automatic chk(input string nm, input int d, input logic [31:0] act,
                       input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30)
                $display("FAIL %s dut%0d at %0t: got %0h expected %0h", nm, d, $time, act, exp);
        end
    endtask

    // ---------------- model ----------------
    logic [7:0] mf [2][DEPTH];
    int         mn    [2];
    bit         mov   [2];
    logic [7:0] fb    [2];
    int         fleft [2];   // clocks left in the frame, including the one on the line

    function automatic int frame_len(input int d);
        return 16 * (9 + PAR + ((d == 0) ? 1 : 2));
    endfunction

    function automatic logic line_bit(input int d);
        int idx;
        if (fleft[d] == 0) return 1'b1;
        idx = (frame_len(d) - fleft[d]) / 16;
        if (idx == 0) return 1'b0;
        if (idx <= 8) return fb[d][idx-1];
        if (PAR == 1 && idx == 9) return ^fb[d];
        return 1'b1;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int d = 0; d < 2; d++) begin
                mn[d] = 0; mov[d] = 1'b0; fleft[d] = 0; fb[d] = 8'h00;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                int pre_n;
                pre_n = mn[d];
                if (fleft[d] > 0) fleft[d]--;
                if (fleft[d] == 0 && pre_n > 0) begin
                    fb[d] = mf[d][0];
                    for (int i = 0; i < DEPTH - 1; i++) mf[d][i] = mf[d][i+1];
                    mn[d]--;
                    fleft[d] = frame_len(d);
                end
                if (wr_s) begin
                    if (pre_n < DEPTH) begin
                        mf[d][mn[d]] = din_s;
                        mn[d]++;
                    end else begin
                        mov[d] = 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && chk_en) begin
            chk("tx",       0, tx0,           line_bit(0));
            chk("tx",       1, tx1,           line_bit(1));
            chk("tx_busy",  0, busy0,         (mn[0] > 0) || (fleft[0] > 0));
            chk("tx_busy",  1, busy1,         (mn[1] > 0) || (fleft[1] > 0));
            chk("count",    0, bus0.count,    mn[0]);
            chk("count",    1, bus1.count,    mn[1]);
            chk("full",     0, bus0.full,     mn[0] == DEPTH);
            chk("full",     1, bus1.full,     mn[1] == DEPTH);
            chk("overflow", 0, bus0.overflow, mov[0]);
            chk("overflow", 1, bus1.overflow, mov[1]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic write_byte(input logic [7:0] b);
        @(negedge clk);
        wr_s  = 1'b1;
        din_s = b;
        @(negedge clk);
        wr_s  = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while ((busy0 || busy1) && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (busy0 || busy1) chk("idle_timeout", 0, 1, 0);
    endtask

    // one byte into an idle block; measures busy length and samples dut0 mid-bit
    task automatic run_frame(input logic [7:0] b, input int exp0, input int exp1,
                             input logic [10:0] bits0);
        int n;
        bit done0, done1;
        write_byte(b);
        n = 0; done0 = 1'b0; done1 = 1'b0;
        while ((!done0 || !done1) && n < 600) begin
            @(negedge clk);
            n++;
            for (int j = 0; j < 11; j++)
                if (n == 9 + 16 * j) chk("tx_bit", 0, tx0, bits0[j]);
            if (n == 169) chk("tx_late", 1, tx1, 1'b1);
            if (!done0 && !busy0) begin done0 = 1'b1; chk("busy_len", 0, n, exp0); end
            if (!done1 && !busy1) begin done1 = 1'b1; chk("busy_len", 1, n, exp1); end
        end
        if (!done0) chk("busy_timeout", 0, 1, 0);
        if (!done1) chk("busy_timeout", 1, 1, 0);
    endtask

    initial begin
        int len0, len1;
        len0 = 161 + 16 * PAR;
        len1 = 177 + 16 * PAR;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        chk("rst_tx", 0, tx0, 1'b1);
        chk("rst_busy", 0, busy0, 1'b0);
        chk("rst_count", 0, bus0.count, 0);
        chk("rst_full", 0, bus0.full, 1'b0);
        chk("rst_ovf", 0, bus0.overflow, 1'b0);
        chk("rst_tx", 1, tx1, 1'b1);
        chk_en = 1'b1;

        // single bytes; bit vectors are line values at mid-bit, index 0 = start
        run_frame(8'h55, len0, len1, (PAR == 1) ? 11'b10010101010 : 11'b11010101010);
        run_frame(8'hA5, len0, len1, (PAR == 1) ? 11'b10101001010 : 11'b11101001010);
        run_frame(8'h07, len0, len1, 11'b11000001110);
        run_frame(8'h03, len0, len1, (PAR == 1) ? 11'b10000000110 : 11'b11000000110);

        // three bytes on consecutive clocks
        @(negedge clk);
        wr_s = 1'b1; din_s = 8'h01;
        @(negedge clk);
        chk("cnt_seq1", 0, bus0.count, 1);
        din_s = 8'h80;
        @(negedge clk);
        chk("cnt_seq2", 0, bus0.count, 1);
        din_s = 8'hFF;
        @(negedge clk);
        wr_s = 1'b0;
        chk("cnt_seq3", 0, bus0.count, 2);
        wait_idle(2000);

        // six writes: fill, then one dropped
        @(negedge clk);
        wr_s = 1'b1;
        for (int i = 0; i < 6; i++) begin
            din_s = 8'h10 + 8'(i);
            @(negedge clk);
        end
        wr_s = 1'b0;
        chk("six_full", 0, bus0.full, 1'b1);
        chk("six_count", 0, bus0.count, 4);
        chk("six_ovf", 0, bus0.overflow, 1'b1);
        wait_idle(2000);
        chk("ovf_sticky", 0, bus0.overflow, 1'b1);

        // reset in the middle of a frame of 0x00 with two more bytes queued
        @(negedge clk);
        wr_s = 1'b1; din_s = 8'h00;
        @(negedge clk);
        din_s = 8'h11;
        @(negedge clk);
        din_s = 8'h22;
        @(negedge clk);
        wr_s = 1'b0;
        repeat (38) @(negedge clk);
        chk("pre_rst_tx", 0, tx0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_tx", 0, tx0, 1'b1);
        chk("mid_rst_tx", 1, tx1, 1'b1);
        chk("mid_rst_count", 0, bus0.count, 0);
        chk("mid_rst_busy", 0, busy0, 1'b0);
        chk("mid_rst_ovf", 0, bus0.overflow, 1'b0);
        @(negedge clk);
        #2 rst = 1'b0;
        repeat (250) @(negedge clk);
        chk("post_rst_tx", 0, tx0, 1'b1);
        chk("post_rst_busy", 0, busy0, 1'b0);

        // randomized traffic: dense bursts then sparse writes
        for (int i = 0; i < 2500; i++) begin
            @(negedge clk);
            wr_s  = ($urandom_range(0, 3) == 0);
            din_s = 8'($urandom);
        end
        @(negedge clk);
        wr_s = 1'b0;
        wait_idle(2000);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            wr_s  = ($urandom_range(0, 60) == 0);
            din_s = 8'($urandom);
        end
        @(negedge clk);
        wr_s = 1'b0;
        wait_idle(2000);
        repeat (4) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_tx16.md
# uart_tx16

Buffered RS-232 transmitter clocked directly from the 16x-oversampled baud clock, the transmit-side counterpart of the 16x receiver on the same `clk_9600_16` domain. Bytes are pushed into a small FIFO and serialized as 8N1 (optionally 8E1) frames with exactly 16 clocks per bit, back-to-back with no idle gap while data is queued. It replaces pulse-per-bit transmit paths so both UART directions share one clock and one bit-timing source.

## Interface
- `FIFO_AW`, 2, FIFO address width; depth = 2**FIFO_AW (4 entries).
- `STOP_BITS`, 1, stop bits per frame; legal values 1 or 2.

- `clk_9600_16`  in  1  16x baud clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `din`  in  8  byte to queue.
- `wr_en`  in  1  write strobe; one byte per cycle while high.
- `full`  out  1  FIFO holds 2**FIFO_AW entries.
- `count`  out  FIFO_AW+1  current FIFO occupancy.
- `overflow`  out  1  sticky; set when `wr_en` is high while `full`.
- `tx`  out  1  serial line, idle high.
- `tx_busy`  out  1  high when FIFO non-empty or FSM not IDLE.

## Operation
- FIFO: write accepted at an edge iff `wr_en` && !`full` (pre-edge value). Write while full is dropped and sets `overflow`; a pop in the same cycle does not rescue it. Pointers wrap modulo depth; `count` = entries, range 0..depth.
- Simultaneous accepted write and pop: `count` unchanged, both pointers advance.
- FSM states: IDLE, START, DATA, PARITY (only with macro), STOP.
- Bit timer `sample` (4 bits) counts 0..15 in every non-IDLE state; the state's bit ends when `sample`==15.
- IDLE: if FIFO non-empty, pop head into shift register, `tx`<=0, `sample`<=0, go START. Otherwise `tx`<=1.
- START -> DATA at end of bit; `tx`<=data[0], `bitpos`<=0.
- DATA: LSB first; at end of each bit, `bitpos`+1 and `tx`<=next bit; after bit 7, go PARITY (`tx`<=parity) or STOP (`tx`<=1).
- STOP: `tx`=1 for 16*STOP_BITS clocks (stop counter is `sample` plus one extra count bit). At end: if FIFO non-empty, pop, `tx`<=0, go START (zero-gap back-to-back); else go IDLE.
- `tx` is registered; no combinational path from `din`/`wr_en` to `tx`.

## Timing
- Reset values: `tx`=1, `tx_busy`=0, `full`=0, `count`=0, `overflow`=0; FSM IDLE, pointers 0, `sample`=0.
- Reset mid-frame: `tx` returns high immediately (async), frame aborted, FIFO flushed, `overflow` cleared.
- Latency: byte written at edge N into empty FIFO with FSM IDLE -> pop and `tx` falls at edge N+1.
- Start bit held edges N+1..N+16; data bit k driven from edge N+17+16k for 16 clocks.
- Frame length: 16*(1+8+STOP_BITS) clocks (160 for 8N1), +16 with parity.
- `tx_busy` rises at edge N (FIFO non-empty), falls at the edge entering IDLE with FIFO empty.
- `full`/`count` reflect the post-edge FIFO state on the same edge as the write/pop.

## Configuration
- `UART_TX16_PARITY_EN` defined: PARITY state inserted after data bit 7; bit = XOR of 8 data bits (even parity), held 16 clocks; frame 8E1/8E2.
- Undefined: PARITY state and its logic absent; DATA goes directly to STOP; frame 8N1/8N2.

## Test plan
- Single byte 0x55 written to idle block -> `tx` low at N+1, then 1,0,1,0,1,0,1,0 (LSB first) each 16 clocks, stop high 16 clocks; `tx_busy` low at edge N+161; total 160 clocks.
- Three bytes 0x01,0x80,0xFF written on consecutive cycles -> three frames with no idle clock between stop and next start; `count` goes 1,1,2 then drains to 0.
- Six writes in consecutive cycles with FIFO_AW=2 while idle -> first popped, next four fill FIFO (`full`=1, `count`=4), sixth dropped, `overflow`=1 and stays 1 until reset.
- With `UART_TX16_PARITY_EN`: byte 0x07 -> parity bit 1 after data bit 7; byte 0x03 -> parity 0; frame 176 clocks.
- Assert `rst` at clock 40 of a frame of 0x00 with 2 bytes queued -> `tx`=1 immediately, `count`=0, `tx_busy`=0, no further start bit after release.
- STOP_BITS=2, byte 0xA5 -> stop level held 32 clocks; frame 176 clocks.
